// File: rtl/reg_alu_exec_pkg.sv
// Shared definitions for the register-file execution stage:
// ALU operation codes, FSM state encoding and default widths.
package reg_alu_exec_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_READ = 2'b01,
    S_EXEC = 2'b10,
    S_WB   = 2'b11
  } state_t;

endpackage

// File: rtl/reg_alu_exec_alu32.sv
// alu32: combinational ALU. Ports: A_i, B_i, op_i in;
// result_o, zf_o (result==0), of_o (signed ADD/SUB overflow) out.
module alu32
  import reg_alu_exec_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] A_i,
  input  logic [DW-1:0] B_i,
  input  logic [2:0]    op_i,
  output logic [DW-1:0] result_o,
  output logic          zf_o,
  output logic          of_o
);

  logic [DW-1:0] sum;
  logic [DW-1:0] diff;
  logic          lt;

  assign sum  = A_i + B_i;
  assign diff = A_i - B_i;
  assign lt   = $signed(A_i) < $signed(B_i);

  always_comb begin
    result_o = '0;
    of_o     = 1'b0;
    case (op_i)
      OP_AND: result_o = A_i & B_i;
      OP_OR:  result_o = A_i | B_i;
      OP_XOR: result_o = A_i ^ B_i;
      OP_NOR: result_o = ~(A_i | B_i);
      OP_ADD: begin
        result_o = sum;
        of_o = (A_i[DW-1] == B_i[DW-1])
            && (sum[DW-1] != A_i[DW-1]);
      end
      OP_SUB: begin
        result_o = diff;
        of_o = (A_i[DW-1] != B_i[DW-1])
            && (diff[DW-1] != A_i[DW-1]);
      end
      OP_SLT: result_o = {{(DW-1){1'b0}}, lt};
      OP_SLL: result_o = B_i << A_i[4:0];
      default: result_o = '0;
    endcase
  end

  assign zf_o = (result_o == '0);

endmodule

// File: rtl/reg_alu_exec.sv
// reg_alu_exec: IDLE->READ->EXEC->WB stage around a register file.
// In: Clk, Reset, Start, Rs/Rt/Rd_Addr, ALU_OP, R_Data_A/B.
// Out: R_Addr_A/B, W_Addr, W_Data, Write_Reg, Busy, Done,
// Result, ZF, OF.
module reg_alu_exec
  import reg_alu_exec_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [AW-1:0] Rs_Addr,
  input  logic [AW-1:0] Rt_Addr,
  input  logic [AW-1:0] Rd_Addr,
  input  logic [2:0]    ALU_OP,
  output logic [AW-1:0] R_Addr_A,
  output logic [AW-1:0] R_Addr_B,
  input  logic [DW-1:0] R_Data_A,
  input  logic [DW-1:0] R_Data_B,
  output logic [AW-1:0] W_Addr,
  output logic [DW-1:0] W_Data,
  output logic          Write_Reg,
  output logic          Busy,
  output logic          Done,
  output logic [DW-1:0] Result,
  output logic          ZF,
  output logic          OF
);

  state_t        state_q;
  logic [AW-1:0] ra_q, rb_q, wa_q;
  logic [2:0]    op_q;
  logic [DW-1:0] a_q, b_q, wd_q, res_q;
  logic          zf_q, of_q, done_q;

  logic [DW-1:0] alu_res;
  logic          alu_zf, alu_of;

  alu32 #(.DW(DW)) u_alu (
    .A_i      (a_q),
    .B_i      (b_q),
    .op_i     (op_q),
    .result_o (alu_res),
    .zf_o     (alu_zf),
    .of_o     (alu_of)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      wa_q    <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      wd_q    <= '0;
      res_q   <= '0;
      zf_q    <= 1'b0;
      of_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (Start) begin
            ra_q    <= Rs_Addr;
            rb_q    <= Rt_Addr;
            wa_q    <= Rd_Addr;
            op_q    <= ALU_OP;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          a_q     <= R_Data_A;
          b_q     <= R_Data_B;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          res_q   <= alu_res;
          zf_q    <= alu_zf;
          of_q    <= alu_of;
          wd_q    <= alu_res;
          state_q <= S_WB;
        end
        S_WB: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Decoded from state so an async reset kills a pending write at once;
  // R0 is never written.
  assign Write_Reg = (state_q == S_WB) && (wa_q != '0);
  assign Busy      = (state_q != S_IDLE);

  assign R_Addr_A = ra_q;
  assign R_Addr_B = rb_q;
  assign W_Addr   = wa_q;
  assign W_Data   = wd_q;
  assign Done     = done_q;
  assign Result   = res_q;
  assign ZF       = zf_q;
  assign OF       = of_q;

endmodule

// File: tb/tb_reg_alu_exec.sv
// Self-checking bench for reg_alu_exec with a behavioural
// 32x32 register file (combinational read, write at clock edge).
module tb_reg_alu_exec;

  logic        Clk = 1'b0;
  logic        Reset, Start;
  logic [4:0]  Rs_Addr, Rt_Addr, Rd_Addr;
  logic [2:0]  ALU_OP;
  logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
  logic [31:0] R_Data_A, R_Data_B, W_Data, Result;
  logic        Write_Reg, Busy, Done, ZF, OF;

  logic [31:0] rf [32];
  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  assign R_Data_A = rf[R_Addr_A];
  assign R_Data_B = rf[R_Addr_B];

  always @(posedge Clk)
    if (Write_Reg && W_Addr != 5'd0) rf[W_Addr] <= W_Data;

  reg_alu_exec dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .Rs_Addr(Rs_Addr), .Rt_Addr(Rt_Addr), .Rd_Addr(Rd_Addr),
    .ALU_OP(ALU_OP),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .R_Data_A(R_Data_A), .R_Data_B(R_Data_B),
    .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg),
    .Busy(Busy), .Done(Done), .Result(Result), .ZF(ZF), .OF(OF)
  );

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [2:0]  op;
    logic [31:0] a, b, res;
    logic        zf, of;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic launch(input logic [4:0] rs, rt, rd,
                        input logic [2:0] op);
    Rs_Addr = rs; Rt_Addr = rt; Rd_Addr = rd; ALU_OP = op;
    Start = 1'b1;
  endtask

  // Called right after launch; returns at the negedge of the Done cycle.
  task automatic watch(input string nm, input logic [4:0] rd,
                       input logic [31:0] res, input logic zf, of,
                       input bit hold);
    @(negedge Clk);
    chk({nm, ".rd_busy"}, Busy, 1);
    chk({nm, ".rd_wr"}, Write_Reg, 0);
    Start = hold;
    Rd_Addr = 5'd9;
    @(negedge Clk);
    chk({nm, ".ex_wr"}, Write_Reg, 0);
    @(negedge Clk);
    chk({nm, ".wb_wr"}, Write_Reg, (rd != 5'd0));
    chk({nm, ".wb_addr"}, W_Addr, rd);
    chk({nm, ".wb_data"}, W_Data, res);
    chk({nm, ".res"}, Result, res);
    chk({nm, ".zf"}, ZF, zf);
    chk({nm, ".of"}, OF, of);
    chk({nm, ".wb_done"}, Done, 0);
    Start = 1'b0;
    @(negedge Clk);
    chk({nm, ".done"}, Done, 1);
    chk({nm, ".idle"}, Busy, 0);
    if (rd != 5'd0) chk({nm, ".rf"}, rf[rd], res);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    vt[0]  = '{5'd1,  5'd2,  5'd3,  3'b100, 32'h0000000F, 32'h0F0F0F00, 32'h0F0F0F0F, 0, 0};
    vt[1]  = '{5'd4,  5'd4,  5'd8,  3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1, 0};
    vt[2]  = '{5'd5,  5'd6,  5'd10, 3'b100, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1};
    vt[3]  = '{5'd5,  5'd6,  5'd11, 3'b101, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1};
    vt[4]  = '{5'd12, 5'd13, 5'd14, 3'b110, 32'hF0F0F0F0, 32'h00000001, 32'h00000001, 0, 0};
    vt[5]  = '{5'd15, 5'd16, 5'd17, 3'b111, 32'h00000004, 32'h0000000F, 32'h000000F0, 0, 0};
    vt[6]  = '{5'd1,  5'd2,  5'd0,  3'b000, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 0, 0};
    vt[7]  = '{5'd18, 5'd19, 5'd20, 3'b001, 32'hF0000000, 32'h0000000F, 32'hF000000F, 0, 0};
    vt[8]  = '{5'd21, 5'd22, 5'd23, 3'b010, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 0, 0};
    vt[9]  = '{5'd24, 5'd25, 5'd26, 3'b011, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 0};
    vt[10] = '{5'd12, 5'd13, 5'd27, 3'b110, 32'h00000001, 32'hF0F0F0F0, 32'h00000000, 1, 0};

    Reset = 1'b1; Start = 1'b0;
    Rs_Addr = '0; Rt_Addr = '0; Rd_Addr = '0; ALU_OP = '0;
    repeat (2) @(negedge Clk);
    chk("rst.busy", Busy, 0);
    chk("rst.done", Done, 0);
    chk("rst.wr", Write_Reg, 0);
    chk("rst.res", Result, 0);
    chk("rst.waddr", W_Addr, 0);
    chk("rst.wdata", W_Data, 0);
    chk("rst.raddr", {R_Addr_A, R_Addr_B}, 0);
    chk("rst.flags", {ZF, OF}, 0);
    Reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 11; i++) begin
      rf[vt[i].rs] = vt[i].a;
      rf[vt[i].rt] = vt[i].b;
      launch(vt[i].rs, vt[i].rt, vt[i].rd, vt[i].op);
      watch($sformatf("v%0d", i), vt[i].rd, vt[i].res,
            vt[i].zf, vt[i].of, 0);
      @(negedge Clk);
      chk($sformatf("v%0d.done_once", i), Done, 0);
    end

    // Back-to-back with read-after-write on R7.
    rf[1] = 32'd5; rf[2] = 32'd3;
    launch(5'd1, 5'd2, 5'd7, 3'b100);
    watch("b2b1", 5'd7, 32'd8, 0, 0, 0);
    launch(5'd7, 5'd2, 5'd28, 3'b100);
    watch("b2b2", 5'd28, 32'd11, 0, 0, 0);
    @(negedge Clk);

    // Start held high while busy must be ignored.
    rf[9] = 32'hDEADBEEF;
    launch(5'd1, 5'd2, 5'd29, 3'b101);
    watch("busy", 5'd29, 32'd2, 0, 0, 1);
    repeat (3) begin
      @(negedge Clk);
      chk("busy.no_extra_done", Done, 0);
      chk("busy.no_restart", Busy, 0);
    end
    chk("busy.rf9", rf[9], 32'hDEADBEEF);

    // Reset during READ.
    rf[30] = 32'h12345678;
    launch(5'd1, 5'd2, 5'd30, 3'b100);
    @(negedge Clk);
    Start = 1'b0;
    Reset = 1'b1;
    #1;
    chk("rstrd.busy", Busy, 0);
    chk("rstrd.wr", Write_Reg, 0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      chk("rstrd.done", Done, 0);
    end
    chk("rstrd.rf", rf[30], 32'h12345678);

    // Reset during WB: pending write must vanish immediately.
    launch(5'd1, 5'd2, 5'd30, 3'b100);
    @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rstwb.wr_pre", Write_Reg, 1);
    Reset = 1'b1;
    #1;
    chk("rstwb.wr", Write_Reg, 0);
    chk("rstwb.busy", Busy, 0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      chk("rstwb.done", Done, 0);
    end
    chk("rstwb.rf", rf[30], 32'h12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
